// File: rtl/wb_ctrl.sv
// Writeback arbiter: merges ALU and load-path register writes through a small
// pending-write FIFO and drives a single registered register-file write port.
module wb_ctrl #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4,
    parameter int NREG  = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [ASIZE-1:0] alu_waddr,
    input  logic [DSIZE-1:0] alu_wdata,
    input  logic             mem_valid,
    input  logic [ASIZE-1:0] mem_waddr,
    input  logic [DSIZE-1:0] mem_wdata,
    output logic             wen,
    output logic [ASIZE-1:0] waddr,
    output logic [DSIZE-1:0] wdata,
    output logic             stall,
    output logic [NREG-1:0]  pend_mask,
    output logic             ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ASIZE-1:0] addr_q [DEPTH];
    logic [DSIZE-1:0] data_q [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic             wen_q;
    logic [ASIZE-1:0] waddr_q;
    logic [DSIZE-1:0] wdata_q;
    logic             ovf_q;

    logic          mem_req, alu_req;
    logic          mem_push, alu_push, pop, drop;
    logic [CW-1:0] free;
    logic [PW-1:0] alu_slot;

    // Free slots are judged on the pre-edge count; a same-cycle pop frees nothing yet.
    assign mem_req  = mem_valid && (mem_waddr != '0);
    assign alu_req  = alu_valid && (alu_waddr != '0);
    assign free     = CW'(DEPTH) - count_q;
    assign mem_push = mem_req && (free >= CW'(1));
    assign alu_push = alu_req && (free >= (mem_push ? CW'(2) : CW'(1)));
    assign drop     = (mem_req && !mem_push) || (alu_req && !alu_push);
    assign pop      = (count_q != '0);
    assign alu_slot = wptr_q + PW'(mem_push);

    assign count_d = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    assign wptr_d  = wptr_q + PW'(mem_push) + PW'(alu_push);
    assign rptr_d  = rptr_q + PW'(pop);

    always_ff @(posedge clk) begin
        if (mem_push) begin
            addr_q[wptr_q] <= mem_waddr;
            data_q[wptr_q] <= mem_wdata;
        end
        if (alu_push) begin
            addr_q[alu_slot] <= alu_waddr;
            data_q[alu_slot] <= alu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            wen_q   <= pop;
            if (pop) begin
                waddr_q <= addr_q[rptr_q];
                wdata_q <= data_q[rptr_q];
            end
            ovf_q <= ovf_q | drop;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int r = 1; r < NREG; r++) begin
            if (wen_q && (waddr_q == ASIZE'(r))) pend_mask[r] = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count_q) && (addr_q[rptr_q + PW'(i)] == ASIZE'(r)))
                    pend_mask[r] = 1'b1;
            end
        end
    end

    assign wen   = wen_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign ovf   = ovf_q;
    assign stall = (count_q > CW'(DEPTH - 2));

endmodule

// File: doc/wb_ctrl.md
WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 The block SHALL have parameter DSIZE, default 16, data width.
REQ-002 The block SHALL have parameter ASIZE, default 4, register address width.
REQ-003 The block SHALL have parameter NREG, default 16, register count.
REQ-004 The block SHALL have parameter DEPTH, default 4, pending-write FIFO depth (power of two, >=4).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have ports alu_valid / alu_waddr / alu_wdata, inputs of widths 1 / ASIZE / DSIZE, the ALU-path writeback request.
REQ-008 The block SHALL have ports mem_valid / mem_waddr / mem_wdata, inputs of widths 1 / ASIZE / DSIZE, the load-path writeback request.
REQ-009 The block SHALL have ports wen / waddr / wdata, outputs of widths 1 / ASIZE / DSIZE, driving the register file write port, all registered.
REQ-010 The block SHALL have port stall, output, 1, telling producers not to present new requests.
REQ-011 The block SHALL have port pend_mask, output, NREG, one bit per register with a write in flight.
REQ-012 The block SHALL have port ovf, output, 1, a sticky overflow error flag.

Function
REQ-013 Each request SHALL be sampled at the posedge where its valid is high.
REQ-014 A request with waddr == 0 SHALL be discarded: not queued and never written.
REQ-015 When both requests are accepted in the same cycle, mem SHALL be enqueued ahead of alu, preserving write-after-write order.
REQ-016 Up to two entries SHALL be pushed per cycle.
REQ-017 At most one entry SHALL be popped per cycle.
REQ-018 The pop SHALL be decided on the pre-edge count; an entry pushed at edge E0 SHALL appear on the outputs no earlier than edge E1.
REQ-019 At each edge with count > 0, the head entry SHALL be loaded into waddr/wdata with wen=1.
REQ-020 At each edge with count == 0, wen SHALL load 0 and waddr/wdata SHALL hold their previous values.
REQ-021 Minimum latency SHALL be: request at edge E0, wen high from E1 to E2, register file written at E2.
REQ-022 The next count SHALL equal count + pushes - pop; the read and write pointers SHALL wrap modulo DEPTH.
REQ-023 stall SHALL be combinational and SHALL equal (count > DEPTH-2), i.e. high when fewer than two free slots remain.
REQ-024 stall SHALL be evaluated on the pre-edge count.
REQ-025 A request that arrives while no free slot remains after earlier pushes in the same cycle SHALL be dropped and SHALL set ovf=1.
REQ-026 ovf SHALL stay set until reset.
REQ-027 A pop and pushes in the same cycle on a full FIFO SHALL treat the popped slot as free only at the next edge.
REQ-028 pend_mask[r] SHALL be combinational and SHALL be 1 iff any valid FIFO entry has waddr r, or wen=1 with waddr == r.
REQ-029 pend_mask[0] SHALL always be 0.

Reset
REQ-030 When rst is low, the block SHALL asynchronously clear the count, both pointers, wen, waddr, wdata and ovf.
REQ-031 Outputs during and after reset SHALL be wen=0, waddr=0, wdata=0, stall=0, pend_mask=0, ovf=0.
REQ-032 Reset mid-operation SHALL discard all queued writes with no partial write issued.
REQ-033 After rst is released, the first request SHALL be accepted at the first posedge.

Verification
REQ-034 Single request: alu_valid with waddr=3, wdata=0x1234 at E0, FIFO empty -> wen=1, waddr=3, wdata=0x1234 during E1-E2; pend_mask[3]=1 from E0+ until E2.
REQ-035 Simultaneous requests: mem r5=0xAAAA and alu r5=0x5555 at E0 -> r5=0xAAAA issued at E1, r5=0x5555 at E2; pend_mask[5] stays high through E3.
REQ-036 Zero-register drop: alu_valid with waddr=0, wdata=0xFFFF -> wen never asserts, pend_mask stays 0, count unchanged.
REQ-037 Fill and stall: two dual pushes on consecutive edges with DEPTH=4 -> stall high once count reaches 3; an extra request on a full FIFO sets ovf=1 and no data is corrupted.
REQ-038 Reset mid-operation: three entries queued, rst pulled low between edges -> wen=0, pend_mask=0 and stall=0 immediately; no write issues after release until a new request arrives.
